seven_segs_scanner: RTL and testbench

Parametrised, time-multiplexed driver for a bank of DIGITS common-anode/cathode seven-segment digits with per-digit decimal points. It is the successor to the fixed six-digit controller. New in this block:
- a programmable scan prescaler;
- PWM brightness;
- a one-cycle anti-ghosting dead time;
- leading-zero blanking;
- selectable output polarity;
- tear-free frame-synchronous data loading.

It sits between the CPU's display register and the board pins.

---
 rtl/seven_segs_scanner.sv | 158 +++++++++++++++
 tb/tb_seven_segs_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segs_scanner.sv
// rtl/seven_segs_scanner.sv - time-multiplexed seven-segment scanner with PWM, blanking and frame-synchronous loading
module seven_segs_scanner #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Data,
  input  logic [DIGITS-1:0]     Points,
  input  logic [DIGITS-1:0]     DisplayEnables,
  input  logic [BRIGHT_W-1:0]   Brightness,
  input  logic                  LeadingZeroBlank,
  output logic [7:0]            SevenSegsAndPoint,
  output logic [DIGITS-1:0]     ShowOneofDigits,
  output logic                  FrameStart,
  output logic                  Pending
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  // XOR masks that also serve as the idle (inactive) output levels
  localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic                boundary;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_pts;
  logic [DIGITS-1:0]   sh_en;
  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_pts;
  logic [DIGITS-1:0]   act_en;
  logic                pending;

  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   blank;
  logic                upper_zero;
  logic [3:0]          cur_nib;
  logic                lit;
  logic [DIGITS-1:0]   onehot;
  logic                wrap_d;

  // Hex nibble to active-high segments, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  assign boundary = (pre == PRE_LAST) && (idx == IDX_LAST);
  assign Pending  = pending;

  // Scan counters: prescaler inside a digit slot, digit index across slots
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Shadow captures on Load; active only updates at a frame boundary so a frame never tears
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sh_data  <= '0;
      sh_pts   <= '0;
      sh_en    <= '0;
      act_data <= '0;
      act_pts  <= '0;
      act_en   <= '0;
      pending  <= 1'b0;
    end else begin
      if (boundary && pending) begin
        act_data <= sh_data;
        act_pts  <= sh_pts;
        act_en   <= sh_en;
      end
      if (Load) begin
        sh_data <= Data;
        sh_pts  <= Points;
        sh_en   <= DisplayEnables;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Split the active data word into per-digit nibbles
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = act_data[4*i +: 4];
    end
  end

  // Leading-zero blanking: scan from the top digit down while every nibble seen so far is zero
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (nib[i] == 4'd0);
      if (i != 0) begin
        blank[i] = LeadingZeroBlank & upper_zero;
      end
    end
  end

  // Lit decision for the current slot: enabled, not blanked, past the dead cycle, inside the PWM window
  always_comb begin
    cur_nib = nib[idx];
    onehot  = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
    lit     = act_en[idx] & ~blank[idx] & (pre != '0) &
              (pre[BRIGHT_W-1:0] < Brightness);
  end

  // Registered pin drive with polarity applied; FrameStart lines up with digit 0's first output cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SevenSegsAndPoint <= SEG_OFF;
      ShowOneofDigits   <= AN_OFF;
      wrap_d            <= 1'b0;
      FrameStart        <= 1'b0;
    end else begin
      SevenSegsAndPoint <= (lit ? {act_pts[idx], decode(cur_nib)} : 8'h00) ^ SEG_OFF;
      ShowOneofDigits   <= (lit ? onehot : '0) ^ AN_OFF;
      wrap_d            <= boundary;
      FrameStart        <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seven_segs_scanner.sv
// tb/tb_seven_segs_scanner.sv - self-checking bench for seven_segs_scanner
module tb_seven_segs_scanner;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  pts;
  logic [3:0]  en;
  logic [1:0]  bright;
  logic        lzb;

  logic [7:0]  seg, seg_n;
  logic [3:0]  an, an_n;
  logic        fs, fs_n;
  logic        pend, pend_n;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_cyc;
  logic [3:0]  m_sh_nib  [DIGITS];
  logic [3:0]  m_act_nib [DIGITS];
  logic [3:0]  m_sh_pts, m_sh_en, m_act_pts, m_act_en;
  bit          m_pend;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_fs;
  logic [6:0]  seg_tab [16];

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  pts;
    logic [3:0]  en;
    logic [1:0]  bright;
    logic        lzb;
    logic [31:0] segs;
  } vec_t;

  vec_t vecs [7];

  seven_segs_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_dut (
    .Clock(clk), .Reset(rst), .Load(load), .Data(data), .Points(pts),
    .DisplayEnables(en), .Brightness(bright), .LeadingZeroBlank(lzb),
    .SevenSegsAndPoint(seg), .ShowOneofDigits(an), .FrameStart(fs), .Pending(pend)
  );

  seven_segs_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_inv (
    .Clock(clk), .Reset(rst), .Load(load), .Data(data), .Points(pts),
    .DisplayEnables(en), .Brightness(bright), .LeadingZeroBlank(lzb),
    .SevenSegsAndPoint(seg_n), .ShowOneofDigits(an_n), .FrameStart(fs_n), .Pending(pend_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_blank(input int i);
    if (!lzb || i == 0) return 1'b0;
    for (int j = i; j < DIGITS; j++) begin
      if (m_act_nib[j] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // one clock: predict outputs from the pre-edge state and live inputs, step the model, compare
  task automatic tick();
    int pre_v, idx_v;
    bit lit_v, bnd;
    if (rst) begin
      exp_seg = 8'h00;
      exp_an  = 4'h0;
      exp_fs  = 1'b0;
      m_cyc   = 0;
      m_pend  = 1'b0;
      m_sh_pts = '0; m_sh_en = '0; m_act_pts = '0; m_act_en = '0;
      for (int i = 0; i < DIGITS; i++) begin
        m_sh_nib[i]  = '0;
        m_act_nib[i] = '0;
      end
    end else begin
      pre_v  = m_cyc % SCAN_DIV;
      idx_v  = (m_cyc / SCAN_DIV) % DIGITS;
      lit_v  = m_act_en[idx_v] && !model_blank(idx_v) && (pre_v != 0) &&
               ((pre_v % (1 << BRIGHT_W)) < int'(bright));
      exp_an  = lit_v ? 4'(1 << idx_v) : 4'h0;
      exp_seg = lit_v ? {m_act_pts[idx_v], seg_tab[m_act_nib[idx_v]]} : 8'h00;
      exp_fs  = (m_cyc % FRAME == 0) && (m_cyc != 0);
      bnd     = (m_cyc % FRAME == FRAME - 1);
      if (bnd && m_pend) begin
        m_act_pts = m_sh_pts;
        m_act_en  = m_sh_en;
        for (int i = 0; i < DIGITS; i++) m_act_nib[i] = m_sh_nib[i];
      end
      if (load) begin
        m_sh_pts = pts;
        m_sh_en  = en;
        for (int i = 0; i < DIGITS; i++) m_sh_nib[i] = data[4*i +: 4];
        m_pend = 1'b1;
      end else if (bnd) begin
        m_pend = 1'b0;
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(exp_seg));
    check("an", 32'(an), 32'(exp_an));
    check("frame_start", 32'(fs), 32'(exp_fs));
    check("pending", 32'(pend), 32'(m_pend));
    check("inverted_dut", {20'h0, seg_n, an_n}, {20'h0, ~exp_seg, ~exp_an});
    check("inverted_dut_flags", {30'h0, fs_n, pend_n}, {30'h0, exp_fs, m_pend});
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    data = d; pts = p; en = e; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    while (m_cyc % FRAME != ph) tick();
  endtask

  initial begin
    int n, cnt;
    bit found;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{16'h1234, 4'b0010, 4'hF,    2'd3, 1'b0, 32'h06_5B_CF_66};
    vecs[1] = '{16'h0050, 4'b0000, 4'hF,    2'd3, 1'b1, 32'h00_00_6D_3F};
    vecs[2] = '{16'h0000, 4'b0000, 4'hF,    2'd3, 1'b1, 32'h00_00_00_3F};
    vecs[3] = '{16'h0050, 4'b0000, 4'hF,    2'd3, 1'b0, 32'h3F_3F_6D_3F};
    vecs[4] = '{16'hABCD, 4'b1111, 4'b0101, 2'd1, 1'b0, 32'h00_FC_00_DE};
    vecs[5] = '{16'h89EF, 4'b0000, 4'hF,    2'd0, 1'b0, 32'h00_00_00_00};
    vecs[6] = '{16'h0100, 4'b0100, 4'hF,    2'd3, 1'b1, 32'h00_86_3F_3F};

    rst = 1'b1; load = 1'b0; data = '0; pts = '0; en = '0; bright = 2'd3; lzb = 1'b0;
    m_cyc = 0; m_pend = 1'b0;

    // reset held three cycles, then time to first FrameStart
    repeat (3) tick();
    check("reset_seg", 32'(seg), 32'h00);
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg_low", 32'(seg_n), 32'hFF);
    check("reset_an_low", 32'(an_n), 32'hF);
    rst = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 200) begin
      tick();
      n++;
      if (fs) found = 1'b1;
    end
    check("first_frame_start_delay", 32'(n), 32'd65);

    // table-driven load/apply vectors sampled at pre=4 of each slot
    for (int v = 0; v < 7; v++) begin
      bright = vecs[v].bright;
      lzb    = vecs[v].lzb;
      do_load(vecs[v].data, vecs[v].pts, vecs[v].en);
      check($sformatf("vec%0d_pending_set", v), 32'(pend), 32'd1);
      n = 0; cnt = 0;
      while (m_pend && n < 200) begin
        tick();
        n++;
        if (an != 4'h0) cnt++;
      end
      check($sformatf("vec%0d_pending_clear", v), 32'(pend), 32'd0);
      if (v == 0) check("dark_before_boundary", 32'(cnt), 32'd0);
      for (int d = 0; d < DIGITS; d++) begin
        logic [7:0] es;
        es = vecs[v].segs[8*d +: 8];
        wait_phase(d * SCAN_DIV + 4);
        tick();
        check($sformatf("vec%0d_digit%0d_seg", v, d), 32'(seg), 32'(es));
        check($sformatf("vec%0d_digit%0d_an", v, d), 32'(an), (es != 8'h00) ? 32'(1 << d) : 32'd0);
      end
    end

    // brightness duty: anode-high cycles across digit 1's slot
    lzb = 1'b0;
    do_load(16'h1234, 4'b0000, 4'hF);
    while (m_pend) tick();
    for (int k = 0; k < 3; k++) begin
      int b_exp;
      bright = (k == 0) ? 2'd1 : (k == 1) ? 2'd3 : 2'd0;
      b_exp  = (k == 0) ? 3 : (k == 1) ? 11 : 0;
      wait_phase(SCAN_DIV);
      cnt = 0;
      repeat (SCAN_DIV) begin
        tick();
        if (an != 4'h0) cnt++;
      end
      check($sformatf("duty_bright%0d", bright), 32'(cnt), 32'(b_exp));
    end

    // load coinciding with a frame boundary while older data is pending
    bright = 2'd3;
    wait_phase(10);
    do_load(16'h1111, 4'b0000, 4'hF);
    wait_phase(FRAME - 1);
    data = 16'hAAAA; load = 1'b1;
    tick();
    load = 1'b0;
    check("coincident_pending_stays", 32'(pend), 32'd1);
    wait_phase(4);
    tick();
    check("coincident_first_frame", 32'(seg), 32'h06);
    wait_phase(FRAME - 1);
    tick();
    check("coincident_pending_clear", 32'(pend), 32'd0);
    wait_phase(4);
    tick();
    check("coincident_second_frame", 32'(seg), 32'h77);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        data = 16'($urandom);
        if ($urandom_range(0, 1) == 1) data = data >> (4 * $urandom_range(1, 4));
        pts  = 4'($urandom);
        en   = 4'($urandom);
        load = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 199) == 0) lzb = 1'($urandom);
      tick();
      load = 1'b0;
    end

    // reset mid-frame at idx=2, pre=7 with data pending
    bright = 2'd3; lzb = 1'b0;
    wait_phase(2 * SCAN_DIV + 3);
    do_load(16'h8888, 4'hF, 4'hF);
    wait_phase(2 * SCAN_DIV + 7);
    check("midreset_pending_before", 32'(pend), 32'd1);
    rst = 1'b1;
    tick();
    check("midreset_an", 32'(an), 32'h0);
    check("midreset_seg", 32'(seg), 32'h00);
    rst = 1'b0;
    cnt = 0;
    repeat (2 * FRAME + 2) begin
      tick();
      if (an != 4'h0) cnt++;
    end
    check("after_reset_dark", 32'(cnt), 32'd0);
    check("after_reset_pending", 32'(pend), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
